tensorcore_result_drain: RTL and testbench
==========================================

TENSORCORE_RESULT_DRAIN -- requirements
Module: tensorcore_result_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of 4x4 FP16 result tiles buffered (power of two, >=2).
REQ-002 SHALL have parameter ELEM_W, default 16, meaning bits per result element (FP16).
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  one-cycle pulse from matrix-unit out_valid; d_in is valid that cycle.
REQ-006 d_in  input  ELEM_W x [3:0][3:0] unpacked  result tile, d_in[row][col].
REQ-007 row_data  output  4*ELEM_W  one tile row; bits [16k+15:16k] = element [row][k].
REQ-008 row_valid  output  1  row_data/row_idx/row_last valid.
REQ-009 row_ready  input  1  downstream accepts; a beat transfers when row_valid && row_ready.
REQ-010 row_idx  output  2  row number of current beat (0..3).
REQ-011 row_last  output  1  high on row 3 of a tile.
REQ-012 overflow  output  1  sticky: a tile was dropped.
REQ-013 clr_overflow  input  1  clears overflow.
REQ-014 tiles_pending  output  clog2(DEPTH)+1  tiles held, including the one in flight.

Function
REQ-015 Upstream has no backpressure; block SHALL capture d_in on every in_valid while tiles_pending < DEPTH.
REQ-016 Captured tiles SHALL drain in arrival order, rows 0,1,2,3, one row per accepted beat.
REQ-017 Latency: tile captured at cycle N into an empty buffer SHALL present row 0 with row_valid=1 at cycle N+1.
REQ-018 row_data/row_idx/row_last SHALL hold stable while row_valid && !row_ready.
REQ-019 row_valid SHALL be 1 iff tiles_pending > 0; no bubble between tiles when next tile is buffered.
REQ-020 Tile slot SHALL free, and tiles_pending decrement, on acceptance of row 3.
REQ-021 Simultaneous capture and row-3 acceptance SHALL leave tiles_pending unchanged; capture succeeds even when full.
REQ-022 in_valid while full with no row-3 acceptance that cycle SHALL drop d_in, leave buffer unchanged, and set overflow next cycle.
REQ-023 overflow SHALL stay set until clr_overflow; simultaneous clr_overflow and new drop SHALL leave overflow=1.
REQ-024 Write/read tile pointers SHALL wrap modulo DEPTH; row counter wraps 3->0 at tile end.
REQ-025 Data SHALL pass bit-exact; no arithmetic on elements.
REQ-026 Control FSM states: EMPTY (row_valid=0), STREAM (row_valid=1, row counter advances on handshake); EMPTY->STREAM on capture; STREAM->EMPTY on row-3 acceptance with no other tile and no same-cycle capture.

Reset
REQ-027 On rst: row_valid=0, row_idx=0, row_last=0, overflow=0, tiles_pending=0, pointers=0, FSM=EMPTY; row_data=0.
REQ-028 rst mid-tile SHALL discard all buffered tiles and partially drained rows; in_valid during rst SHALL be ignored.
REQ-029 Tile storage contents need not be reset.

Structure
REQ-030 Shared package tc_pkg SHALL hold ELEM_W, TILE_DIM=4, ROW_W=4*ELEM_W and the tile-row type.
REQ-031 Tile storage SHALL be a sub-module tile_fifo (write one full tile, read one row by pointer+row index); control stays in top.

Verification
REQ-032 Single tile d_in[r][c]=16'h1000+4r+c, row_ready=1 -> rows at N+1..N+4, row0=64'h1003_1002_1001_1000, row_last only on row 3.
REQ-033 Two in_valid pulses back-to-back, row_ready=1 -> 8 consecutive beats, no gap, tile order preserved.
REQ-034 row_ready=0 while three tiles arrive (DEPTH=2) -> tiles_pending=2, overflow=1, after release only first two tiles drain.
REQ-035 Full buffer, in_valid in same cycle as row-3 acceptance -> no overflow, new tile drains third.
REQ-036 row_ready toggling 1010... during a tile -> row_data stable when stalled, rows 0..3 each exactly once.
REQ-037 rst asserted after row 1 of a tile accepted -> next cycle row_valid=0, tiles_pending=0; next tile starts at row_idx=0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared constants and types for the tensor-core result drain path.
// Element width, tile geometry, the tile-row type and the drain FSM encoding.
package tc_pkg;

    localparam int ELEM_W   = 16;
    localparam int TILE_DIM = 4;
    localparam int ROW_W    = TILE_DIM * ELEM_W;

    typedef logic [ROW_W-1:0] tile_row_t;

    // EMPTY: nothing to present. STREAM: a tile row is on row_data.
    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/tensorcore_result_drain_tile_fifo.sv
// Tile storage: writes one complete 4x4 tile per cycle, reads one packed row
// selected by tile pointer and row index. Contents are not reset.
module tile_fifo
    import tc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int EW    = tc_pkg::ELEM_W
) (
    input  logic                               clk,
    input  logic                               i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]           i_wr_ptr,
    input  logic [EW-1:0]                      i_wr_tile [TILE_DIM-1:0][TILE_DIM-1:0],
    input  logic [$clog2(DEPTH)-1:0]           i_rd_ptr,
    input  logic [1:0]                         i_rd_row,
    output logic [TILE_DIM*EW-1:0]             o_rd_data
);

    localparam int RW = TILE_DIM * EW;

    logic [RW-1:0] r_mem [DEPTH][TILE_DIM];

    // Element [row][k] lands in bits [EW*k +: EW] of the stored row.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int r = 0; r < TILE_DIM; r++) begin
                for (int c = 0; c < TILE_DIM; c++) begin
                    r_mem[i_wr_ptr][r][c*EW +: EW] <= i_wr_tile[r][c];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr][i_rd_row];

endmodule

// File: rtl/tensorcore_result_drain.sv
// Buffers 4x4 result tiles from the matrix unit (no upstream backpressure) and
// drains them row by row over a valid/ready stream, flagging dropped tiles.
module tensorcore_result_drain
    import tc_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ELEM_W = tc_pkg::ELEM_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [ELEM_W-1:0]            d_in [3:0][3:0],
    output logic [4*ELEM_W-1:0]          row_data,
    output logic                         row_valid,
    input  logic                         row_ready,
    output logic [1:0]                   row_idx,
    output logic                         row_last,
    output logic                         overflow,
    input  logic                         clr_overflow,
    output logic [$clog2(DEPTH):0]       tiles_pending,
    output logic                         dbg_state
);

    // Stream handshake: a beat moves on a cycle where row_valid && row_ready;
    // while row_valid is high and row_ready is low, row_data/row_idx/row_last hold.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    drain_state_t       r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [1:0]         r_row, w_row_nxt;
    logic [CNT_W-1:0]   r_pending, w_pending_nxt;
    logic               r_overflow, w_overflow_nxt;

    logic               w_accept;
    logic               w_last_acc;
    logic               w_capture;
    logic               w_drop;
    logic [4*ELEM_W-1:0] w_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_row      <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_row      <= w_row_nxt;
            r_pending  <= w_pending_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_row_nxt      = r_row;
        w_pending_nxt  = r_pending;
        w_overflow_nxt = r_overflow;

        w_accept   = (r_state == ST_STREAM) && row_ready;
        w_last_acc = w_accept && (r_row == 2'd3);
        // Freeing the slot on the row-3 beat makes room for a same-cycle capture.
        w_capture  = in_valid && ((r_pending < FULL_CNT) || w_last_acc);
        w_drop     = in_valid && !w_capture;

        if (w_accept) begin
            w_row_nxt = r_row + 2'd1;
        end
        if (w_last_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end
        if (w_capture) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end

        case ({w_capture, w_last_acc})
            2'b10:   w_pending_nxt = r_pending + CNT_W'(1);
            2'b01:   w_pending_nxt = r_pending - CNT_W'(1);
            default: w_pending_nxt = r_pending;
        endcase

        // A new drop wins over a same-cycle clear.
        w_overflow_nxt = w_drop || (r_overflow && !clr_overflow);

        case (r_state)
            ST_EMPTY: begin
                if (w_capture) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_last_acc && (r_pending == CNT_W'(1)) && !w_capture) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    tile_fifo #(
        .DEPTH (DEPTH),
        .EW    (ELEM_W)
    ) u_tile_fifo (
        .clk       (clk),
        .i_wr_en   (w_capture),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_tile (d_in),
        .i_rd_ptr  (r_rd_ptr),
        .i_rd_row  (r_row),
        .o_rd_data (w_rd_data)
    );

    assign row_valid     = (r_state == ST_STREAM);
    assign row_data      = row_valid ? w_rd_data : '0;
    assign row_idx       = r_row;
    assign row_last      = row_valid && (r_row == 2'd3);
    assign overflow      = r_overflow;
    assign tiles_pending = r_pending;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_tensorcore_result_drain.sv
// Directed bench for tensorcore_result_drain: a tile-queue model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_tensorcore_result_drain;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] d_in [3:0][3:0];
  logic [63:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic [1:0]  row_idx;
  logic        row_last;
  logic        overflow;
  logic        clr_overflow;
  logic [1:0]  tiles_pending;
  logic        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // model: queue of whole tiles in arrival order, plus the row being presented
  logic [255:0] m_tiles [$];
  int           m_row = 0;
  bit           m_ovf = 1'b0;

  tensorcore_result_drain #(.DEPTH(DEPTH), .ELEM_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .d_in          (d_in),
    .row_data      (row_data),
    .row_valid     (row_valid),
    .row_ready     (row_ready),
    .row_idx       (row_idx),
    .row_last      (row_last),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .tiles_pending (tiles_pending),
    .dbg_state     (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [255:0] pack_tile();
    logic [255:0] t;
    for (int r = 0; r < 4; r++)
      t[r*64 +: 64] = {d_in[r][3], d_in[r][2], d_in[r][1], d_in[r][0]};
    return t;
  endfunction

  task automatic set_tile(input logic [15:0] base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        d_in[r][c] = base + 16'(4 * r + c);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // model update from the rules: drain in order, free on row 3, capture if room
  always @(posedge clk) begin
    bit acc, last, cap, drop;
    if (rst) begin
      m_tiles.delete();
      m_row = 0;
      m_ovf = 1'b0;
    end else begin
      acc  = (m_tiles.size() > 0) && row_ready;
      last = acc && (m_row == 3);
      cap  = in_valid && ((m_tiles.size() < DEPTH) || last);
      drop = in_valid && !cap;
      if (last) begin
        void'(m_tiles.pop_front());
        m_row = 0;
      end else if (acc) begin
        m_row++;
      end
      if (cap) m_tiles.push_back(pack_tile());
      m_ovf = drop || (m_ovf && !clr_overflow);
    end
  end

  // scoreboard compare every cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("row_valid", 64'(row_valid), 64'(m_tiles.size() > 0));
      chk("tiles_pending", 64'(tiles_pending), 64'(m_tiles.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("dbg_state", 64'(dbg_state), 64'(m_tiles.size() > 0));
      if (m_tiles.size() > 0) begin
        chk("row_data", row_data, m_tiles[0][m_row*64 +: 64]);
        chk("row_idx", 64'(row_idx), 64'(m_row));
        chk("row_last", 64'(row_last), 64'(m_row == 3));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; row_ready = 1'b1; clr_overflow = 1'b0;
    set_tile(16'hdead);
    @(posedge clk);
    cmp_en = 1'b1;
    repeat (2) step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_pending", 64'(tiles_pending), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_row_data", row_data, 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_row_last", 64'(row_last), 64'd0);

    // single tile, latency and row layout
    step(); set_tile(16'h1000); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    #1;
    chk("t1_valid_n1", 64'(row_valid), 64'd1);
    chk("t1_row0", row_data, 64'h1003_1002_1001_1000);
    chk("t1_idx0", 64'(row_idx), 64'd0);
    chk("t1_last0", 64'(row_last), 64'd0);
    step(); step(); step();
    #1;
    chk("t1_row3", row_data, 64'h100f_100e_100d_100c);
    chk("t1_idx3", 64'(row_idx), 64'd3);
    chk("t1_last3", 64'(row_last), 64'd1);
    step();
    #1;
    chk("t1_done", 64'(row_valid), 64'd0);

    // back-to-back tiles, 8 beats without a gap
    step(); set_tile(16'h2000); in_valid = 1'b1;
    step(); set_tile(16'h2100);
    step(); in_valid = 1'b0;
    repeat (9) step();
    #1;
    chk("b2b_drained", 64'(tiles_pending), 64'd0);

    // three tiles while stalled: third dropped
    row_ready = 1'b0; set_tile(16'h3000); in_valid = 1'b1;
    step(); set_tile(16'h3100);
    step(); set_tile(16'h3200);
    step(); in_valid = 1'b0;
    #1;
    chk("ovf_pending", 64'(tiles_pending), 64'd2);
    chk("ovf_set", 64'(overflow), 64'd1);
    row_ready = 1'b1;
    repeat (10) step();
    #1;
    chk("ovf_drained", 64'(tiles_pending), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    clr_overflow = 1'b1;
    step(); clr_overflow = 1'b0;
    #1;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // capture on the row-3 acceptance cycle while full
    row_ready = 1'b0; set_tile(16'h4000); in_valid = 1'b1;
    step(); set_tile(16'h4100);
    step(); in_valid = 1'b0; row_ready = 1'b1;
    step(); step(); step();
    set_tile(16'h4200); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    #1;
    chk("full_cap_ovf", 64'(overflow), 64'd0);
    chk("full_cap_pending", 64'(tiles_pending), 64'd2);
    chk("full_cap_row", row_data, 64'h4103_4102_4101_4100);
    repeat (10) step();

    // ready toggling 1010 during a tile
    row_ready = 1'b0; set_tile(16'h5000); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      row_ready = (i % 2 == 0);
      step();
    end
    row_ready = 1'b1;
    repeat (2) step();

    // drop and clear on the same cycle keeps overflow set
    row_ready = 1'b0; set_tile(16'h5100); in_valid = 1'b1;
    step(); set_tile(16'h5200);
    step(); set_tile(16'h5300);
    step(); set_tile(16'h5400); clr_overflow = 1'b1;
    step(); in_valid = 1'b0; clr_overflow = 1'b0;
    #1;
    chk("drop_clr_ovf", 64'(overflow), 64'd1);
    chk("drop_clr_pending", 64'(tiles_pending), 64'd2);
    clr_overflow = 1'b1;
    step(); clr_overflow = 1'b0;
    #1;
    chk("clr_only", 64'(overflow), 64'd0);
    row_ready = 1'b1;
    repeat (9) step();

    // reset mid-tile
    set_tile(16'h6000); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step(); rst = 1'b0;
    #1;
    chk("midrst_valid", 64'(row_valid), 64'd0);
    chk("midrst_pending", 64'(tiles_pending), 64'd0);
    set_tile(16'h6100); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    #1;
    chk("midrst_next_idx", 64'(row_idx), 64'd0);
    chk("midrst_next_row", row_data, 64'h6103_6102_6101_6100);
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
